hex_display_sequencer: RTL and testbench
========================================

// Module: hex_display_sequencer
// PURPOSE
//   Drives NUM_DIGITS active-low 7-segment HEX displays through one shared hex7seg decoder.
//   - Accepts a packed hex word over a valid/ready handshake.
//   - Walks the digits one per clock, writing each decoded pattern into its own per-digit output register.
//   - Sits between effect status/parameter logic and the board HEX pins; outputs hold between updates.
// PARAMETERS
//   NUM_DIGITS  4  number of displays driven, legal 1..8
// PORTS
//   clk         in   1              system clock; all logic on rising edge
//   rst         in   1              synchronous, active-high reset
//   load_valid  in   1              request to display value_in
//   load_ready  out  1              high when a new word is accepted
//   value_in    in   4*NUM_DIGITS   nibble i (bits 4i+3:4i) shown on digit i
//   blank_in    in   1              sampled with load; 1 = show all digits dark
//   seg_out     out  7*NUM_DIGITS   digit i pattern at bits 7i+6:7i, active-low
//   busy        out  1              scan in progress
//   done        out  1              one-cycle pulse, scan complete
// BEHAVIOUR
//   Reset: seg_out = all 7'h7F (every segment off); load_ready=0 while rst=1; busy=0; done=0; state=IDLE; idx=0.
//   FSM states:
//     IDLE: load_ready=1. At an edge with load_valid=1, latch value_in and blank_in, set idx=0, go to SCAN.
//     SCAN: load_ready=0, busy=1. Each edge writes seg_out[idx] = blank ? 7'h7F : hex7seg(nibble idx), then idx++.
//       The edge that writes digit NUM_DIGITS-1 returns to IDLE and sets done=1 for exactly one cycle.
//   Latency: load accepted at edge t -> digit i updated at edge t+1+i; done is high in the cycle after edge t+NUM_DIGITS.
//   Next load: load_ready is high again in that same cycle, so back-to-back loads are NUM_DIGITS+1 cycles apart.
//   Holding: digits not yet rewritten keep their previous pattern; there is no glitch to blank between updates.
//   Ignored inputs: load_valid is ignored outside IDLE, with no queueing; value_in changes after acceptance have no effect.
//   Reset mid-scan: aborts the scan; all digits go to 7'h7F; no done pulse.
//   idx width is clog2(NUM_DIGITS) with a minimum of 1. With NUM_DIGITS=1, SCAN lasts one cycle.
//   Decode table: 0-F map exactly to the standard hex7seg table (e.g. 0->7'h40, 8->7'h00, F->7'h0E).
// CONFIGURATION
//   LZ_BLANK_EN defined:
//     - Leading zeros are blanked: every digit above the highest nonzero nibble is written 7'h7F.
//     - Digit 0 is never blanked by this rule; value 0 shows a single "0".
//     - The mask is computed from the latched word at acceptance.
//   LZ_BLANK_EN undefined: all digits are decoded, including leading zeros. No blanking mask logic is generated.
//   In both cases blank_in overrides everything.
// STRUCTURE
//   Shared package hex_display_pkg:
//     - SEG_BLANK = 7'h7F
//     - state enum {IDLE, SCAN}
//     - function seg_slice(i) returning the bit offset 7*i
//   Sub-module: one hex7seg instance, the single shared decoder.
//     - Input: the latched nibble selected by idx.
//     - Output: registered into seg_out slice idx.
//   Remaining logic:
//     - FSM
//     - idx counter
//     - latched word/blank registers
//     - leading-zero mask (macro-gated)
// TESTING
//   1 Reset, NUM_DIGITS=4: assert rst 3 cycles -> seg_out=28'hFFFFFFF, load_ready=0, busy=0, done=0. Deassert -> load_ready=1.
//   2 Load value_in=16'h1234 at edge t -> digit0=7'h19 at t+1, digit1=7'h30 at t+2, digit2=7'h24 at t+3, digit3=7'h79 at t+4.
//       done high in the cycle after edge t+4; busy high for cycles t+1..t+4.
//   3 Hold load_valid=1 with value_in changing during the scan -> only the first word is displayed.
//       Second acceptance happens exactly at the edge where done=1.
//   4 Load 16'h00A0 -> with LZ_BLANK_EN, digits 3..0 = 7F,7F,08,40; without it, 40,40,08,40. Load 16'h0000 with LZ_BLANK_EN -> 7F,7F,7F,40.
//   5 Load 16'hFFFF with blank_in=1 -> all digits 7'h7F, done pulses normally.
//   6 Load 16'h8888, assert rst at edge t+2 -> all digits 7'h7F on that edge, no done pulse, load_ready=1 after rst drops.

Source files
------------

// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Shared constants, FSM state type and slice helper for the
//            hex display sequencer.
// Revision : 1.0  initial release
// ============================================================================
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int unsigned seg_slice(input int unsigned i);
    return 7 * i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_sequencer_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Active-low nibble to 7-segment decoder, bit order {g,f,e,d,c,b,a}.
// Revision : 1.0  initial release
// ============================================================================
module hex7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_sequencer
// Purpose  : Scans a latched hex word onto NUM_DIGITS active-low 7-segment
//            displays, one digit per clock, through a single shared decoder.
//            Optional macro LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module hex_display_sequencer
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    blank_in,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_value;
  logic                      r_blank;
  logic                      r_done;
  logic [6:0]                r_seg [NUM_DIGITS];

  logic                      w_ready;
  logic                      w_busy;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_lz_hit;
  logic [3:0]                w_nibble;
  logic [6:0]                w_dec;
  logic [6:0]                w_seg_wr;

  assign w_last   = (r_idx == c_last_idx);
  assign w_accept = load_valid & w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~rst;
        if (w_accept) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

`ifdef LZ_BLANK_EN
  // Mask bit i set when nibble i and everything above it are zero; digit 0 never masked.
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic [NUM_DIGITS-1:0] r_lz_mask;
  logic                  w_zero_above;

  always_comb begin
    w_lz_mask    = '0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_above = w_zero_above & (value_in[4*i +: 4] == 4'h0);
      w_lz_mask[i] = w_zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lz_mask <= '0;
    end else if (w_accept) begin
      r_lz_mask <= w_lz_mask;
    end
  end

  assign w_lz_hit = r_lz_mask[r_idx];
`else
  assign w_lz_hit = 1'b0;
`endif

  assign w_seg_wr = (r_blank || w_lz_hit) ? SEG_BLANK : w_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_value <= '0;
      r_blank <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_seg[i] <= SEG_BLANK;
      end
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == SCAN) && w_last;
      if (w_accept) begin
        r_value <= value_in;
        r_blank <= blank_in;
        r_idx   <= '0;
      end
      if (r_state == SCAN) begin
        r_seg[r_idx] <= w_seg_wr;
        r_idx        <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
    assign seg_out[seg_slice(g) +: 7] = r_seg[g];
  end

  assign load_ready = w_ready;
  assign busy       = w_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_sequencer
// Purpose  : Self-checking bench with a timestamp-based display model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hex_display_sequencer;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [4*N-1:0] value_in = '0;
  logic           blank_in = 1'b0;
  logic [7*N-1:0] seg_out;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_display_sequencer #(.NUM_DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .value_in   (value_in),
    .blank_in   (blank_in),
    .seg_out    (seg_out),
    .busy       (busy),
    .done       (done)
  );

  // Model: what each digit shows, plus when the current scan was accepted.
  logic [6:0] m_seg [N];
  logic [6:0] m_tgt [N];
  int         m_t;
  int         e_cnt = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  logic       m_rst = 1'b1;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic compute_target(input logic [4*N-1:0] val, input logic b);
    int hi;
    hi = 0;
    for (int i = 0; i < N; i++) if (val[4*i +: 4] != 4'h0) hi = i;
    for (int i = 0; i < N; i++) begin
      m_tgt[i] = dec(val[4*i +: 4]);
`ifdef LZ_BLANK_EN
      if (i > hi) m_tgt[i] = 7'h7F;
`endif
      if (b) m_tgt[i] = 7'h7F;
    end
  endtask

  task automatic model_edge(input logic v, input logic [4*N-1:0] val, input logic b, input logic r);
    int k;
    e_cnt++;
    m_done = 0;
    m_rst  = r;
    if (r) begin
      for (int i = 0; i < N; i++) m_seg[i] = 7'h7F;
      m_active = 0;
    end else if (m_active) begin
      k = e_cnt - m_t - 1;
      m_seg[k] = m_tgt[k];
      if (k == N - 1) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (v) begin
      m_active = 1;
      m_t      = e_cnt;
      compute_target(val, b);
    end
  endtask

  task automatic compare_model();
    logic [7*N-1:0] exp_seg;
    logic [7*N+2:0] act, expv;
    for (int i = 0; i < N; i++) exp_seg[7*i +: 7] = m_seg[i];
    expv = {exp_seg, (!m_active && !m_rst), logic'(m_active), logic'(m_done)};
    act  = {seg_out, load_ready, busy, done};
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL model edge=%0d {seg,ready,busy,done} actual=%h expected=%h", e_cnt, act, expv);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic step(input logic v, input logic [4*N-1:0] val, input logic b, input logic r);
    load_valid = v;
    value_in   = val;
    blank_in   = b;
    rst        = r;
    @(posedge clk);
    model_edge(v, val, b, r);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    @(negedge clk);
    // Reset held for three edges
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    check("reset_state", {seg_out, load_ready, busy, done}, {28'hFFFFFFF, 3'b000});
    step(1'b0, '0, 1'b0, 1'b0);
    check("ready_after_reset", load_ready, 1'b1);

    // Basic load, digit-by-digit latency
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("busy_after_accept", {load_ready, busy}, 2'b01);
    step(1'b0, '0, 1'b0, 1'b0);
    check("digit0_t1", seg_out[6:0], 7'h19);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    check("scan_1234", {seg_out, load_ready, busy, done}, {7'h79, 7'h24, 7'h30, 7'h19, 3'b101});

    // Held load_valid with changing value: only first word shown, next accept at done edge
    step(1'b1, 16'hABCD, 1'b0, 1'b0);
    repeat (4) step(1'b1, 16'($urandom), 1'b0, 1'b0);
    check("hold_first_word", {seg_out, done}, {7'h08, 7'h03, 7'h46, 7'h21, 1'b1});
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    check("accept_at_done_edge", {busy, done}, 2'b10);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    check("scan_5555", seg_out, {7'h12, 7'h12, 7'h12, 7'h12});

    // Leading zeros
    step(1'b1, 16'h00A0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
`ifdef LZ_BLANK_EN
    check("lz_00A0", seg_out, {7'h7F, 7'h7F, 7'h08, 7'h40});
`else
    check("lz_00A0", seg_out, {7'h40, 7'h40, 7'h08, 7'h40});
`endif
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
`ifdef LZ_BLANK_EN
    check("lz_0000", seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    check("lz_0000", seg_out, {7'h40, 7'h40, 7'h40, 7'h40});
`endif

    // Blank override
    step(1'b1, 16'hFFFF, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    check("blank_ffff", {seg_out, done}, {28'hFFFFFFF, 1'b1});

    // Reset mid-scan
    step(1'b1, 16'h8888, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("mid_digit0", seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h00});
    step(1'b0, '0, 1'b0, 1'b1);
    check("mid_reset", {seg_out, load_ready, busy, done}, {28'hFFFFFFF, 3'b000});
    step(1'b0, '0, 1'b0, 1'b0);
    check("after_mid_reset", {load_ready, busy, done}, 3'b100);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 1) == 1), 16'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
